unary_result_checker: RTL and testbench

// - Receiving end for the unary-operator results of the unary_gates block: accepts one operand plus
//   its claimed ~a, +a, -a and reduction results, recomputes them bit-serially (LSB first) and reports

---
 rtl/unary_check_pkg.sv | 25 ++
 rtl/unary_serial_lane.sv | 74 +++++++
 rtl/unary_result_checker.sv | 149 ++++++++++++++
 tb/tb_unary_result_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/unary_check_pkg.sv
// Purpose : shared types and constants for the unary-operator result checker.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package unary_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Bit positions in out_err_mask
    localparam int ERR_AND  = 0;
    localparam int ERR_OR   = 1;
    localparam int ERR_XOR  = 2;
    localparam int ERR_XNOR = 3;
    localparam int ERR_LNOT = 4;
    localparam int ERR_NOT  = 5;
    localparam int ERR_POS  = 6;
    localparam int ERR_NEG  = 7;

    localparam int NUM_OPS  = 8;
    localparam int RED_W    = 5;

endpackage

// File: rtl/unary_serial_lane.sv
// Purpose : per-bit accumulators (&, |, ^), two's-complement carry tracker and
//           vector-error flags for one LSB-first serial scan of an operand.
// Latency : state updates one cycle after en; *_nxt outputs are combinational and
//           already include the bit currently presented.
// Backpressure: none, advances whenever en is high; clr wins over en.
// Ports   : clk, rst_n, clr (start new scan), en (consume one bit), a_bit/not_bit/
//           pos_bit/neg_bit (current LSBs), *_nxt (accumulator values after this bit).
module unary_serial_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a_bit,
    input  logic not_bit,
    input  logic pos_bit,
    input  logic neg_bit,
    output logic and_nxt,
    output logic or_nxt,
    output logic xor_nxt,
    output logic err_not_nxt,
    output logic err_pos_nxt,
    output logic err_neg_nxt
);

    logic and_acc;
    logic or_acc;
    logic xor_acc;
    logic seen_one;
    logic err_not;
    logic err_pos;
    logic err_neg;
    logic seen_nxt;

    // -a is formed LSB first: bits up to and including the first 1 are copied,
    // every bit after that is inverted. This covers 0 and 2^(WIDTH-1) naturally.
    always_comb begin
        and_nxt     = and_acc & a_bit;
        or_nxt      = or_acc  | a_bit;
        xor_nxt     = xor_acc ^ a_bit;
        err_not_nxt = err_not | (not_bit != ~a_bit);
        err_pos_nxt = err_pos | (pos_bit != a_bit);
        err_neg_nxt = err_neg | (neg_bit != (a_bit ^ seen_one));
        seen_nxt    = seen_one | a_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_acc  <= 1'b0;
            or_acc   <= 1'b0;
            xor_acc  <= 1'b0;
            seen_one <= 1'b0;
            err_not  <= 1'b0;
            err_pos  <= 1'b0;
            err_neg  <= 1'b0;
        end else if (clr) begin
            and_acc  <= 1'b1;
            or_acc   <= 1'b0;
            xor_acc  <= 1'b0;
            seen_one <= 1'b0;
            err_not  <= 1'b0;
            err_pos  <= 1'b0;
            err_neg  <= 1'b0;
        end else if (en) begin
            and_acc  <= and_nxt;
            or_acc   <= or_nxt;
            xor_acc  <= xor_nxt;
            seen_one <= seen_nxt;
            err_not  <= err_not_nxt;
            err_pos  <= err_pos_nxt;
            err_neg  <= err_neg_nxt;
        end
    end

endmodule

// File: rtl/unary_result_checker.sv
// Purpose : re-checks claimed ~a, +a, -a and reduction results bit-serially and
//           reports a per-operator error mask plus a saturating failure count.
// Latency : accept in cycle T -> out_valid in cycle T+WIDTH+1; one txn per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; REPORT holds outputs until out_valid & out_ready.
// Ports   : clk, rst_n; in_valid/in_ready with in_operand/in_not/in_pos/in_neg/in_red;
//           out_valid/out_ready with out_pass/out_err_mask; err_count.
module unary_result_checker
    import unary_check_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_operand,
    input  logic [WIDTH-1:0]     in_not,
    input  logic [WIDTH-1:0]     in_pos,
    input  logic [WIDTH-1:0]     in_neg,
    input  logic [RED_W-1:0]     in_red,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_pass,
    output logic [NUM_OPS-1:0]   out_err_mask,
    output logic [CNT_W-1:0]     err_count
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    opnd_sr;
    logic [WIDTH-1:0]    not_sr;
    logic [WIDTH-1:0]    pos_sr;
    logic [WIDTH-1:0]    neg_sr;
    logic [RED_W-1:0]    red_hold;
    logic [CW-1:0]       bit_cnt;

    logic                accept;
    logic                scanning;
    logic                last_bit;
    logic                and_nxt;
    logic                or_nxt;
    logic                xor_nxt;
    logic                err_not_nxt;
    logic                err_pos_nxt;
    logic                err_neg_nxt;
    logic [NUM_OPS-1:0]  mask_nxt;

    assign accept   = in_valid && (state_q == IDLE);
    assign scanning = (state_q == SCAN);
    assign last_bit = scanning && (bit_cnt == LAST_BIT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SCAN;
            SCAN:    if (last_bit)  state_d = REPORT;
            REPORT:  if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == REPORT);
    end

    // ---------------- operand / claim shift registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_sr  <= '0;
            not_sr   <= '0;
            pos_sr   <= '0;
            neg_sr   <= '0;
            red_hold <= '0;
            bit_cnt  <= '0;
        end else if (accept) begin
            opnd_sr  <= in_operand;
            not_sr   <= in_not;
            pos_sr   <= in_pos;
            neg_sr   <= in_neg;
            red_hold <= in_red;
            bit_cnt  <= '0;
        end else if (scanning) begin
            opnd_sr  <= opnd_sr >> 1;
            not_sr   <= not_sr  >> 1;
            pos_sr   <= pos_sr  >> 1;
            neg_sr   <= neg_sr  >> 1;
            bit_cnt  <= bit_cnt + CW'(1);
        end
    end

    unary_serial_lane u_lane (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept),
        .en          (scanning),
        .a_bit       (opnd_sr[0]),
        .not_bit     (not_sr[0]),
        .pos_bit     (pos_sr[0]),
        .neg_bit     (neg_sr[0]),
        .and_nxt     (and_nxt),
        .or_nxt      (or_nxt),
        .xor_nxt     (xor_nxt),
        .err_not_nxt (err_not_nxt),
        .err_pos_nxt (err_pos_nxt),
        .err_neg_nxt (err_neg_nxt)
    );

    // Lane *_nxt values already include the final bit during the last SCAN cycle,
    // so the verdict can be registered on the same edge that enters REPORT.
    always_comb begin
        mask_nxt           = '0;
        mask_nxt[ERR_AND]  = red_hold[0] ^ and_nxt;
        mask_nxt[ERR_OR]   = red_hold[1] ^ or_nxt;
        mask_nxt[ERR_XOR]  = red_hold[2] ^ xor_nxt;
        mask_nxt[ERR_XNOR] = red_hold[3] ^ ~xor_nxt;
        mask_nxt[ERR_LNOT] = red_hold[4] ^ ~or_nxt;
        mask_nxt[ERR_NOT]  = err_not_nxt;
        mask_nxt[ERR_POS]  = err_pos_nxt;
        mask_nxt[ERR_NEG]  = err_neg_nxt;
    end

    // ---------------- report registers and failure counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pass     <= 1'b0;
            out_err_mask <= '0;
            err_count    <= '0;
        end else if (last_bit) begin
            out_pass     <= ~|mask_nxt;
            out_err_mask <= mask_nxt;
            if ((|mask_nxt) && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_unary_result_checker.sv
module tb_unary_result_checker;
    import unary_check_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_operand;
    logic [7:0]  in_not;
    logic [7:0]  in_pos;
    logic [7:0]  in_neg;
    logic [4:0]  in_red;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic        out_pass;
    logic [7:0]  out_err_mask;
    logic [15:0] err_count;

    // Narrow-counter instance sharing all inputs: exercises saturation quickly.
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_pass;
    logic [7:0]  s_out_err_mask;
    logic [1:0]  s_err_count;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_sat;

    unary_result_checker #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_operand(in_operand), .in_not(in_not), .in_pos(in_pos), .in_neg(in_neg),
        .in_red(in_red), .out_valid(out_valid), .out_ready(out_ready),
        .out_pass(out_pass), .out_err_mask(out_err_mask), .err_count(err_count)
    );

    unary_result_checker #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_operand(in_operand), .in_not(in_not), .in_pos(in_pos), .in_neg(in_neg),
        .in_red(in_red), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pass(s_out_pass), .out_err_mask(s_out_err_mask), .err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] nt;
        logic [7:0] pos;
        logic [7:0] neg;
        logic [4:0] red;
        logic [7:0] mask;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        in_operand = v.a;
        in_not     = v.nt;
        in_pos     = v.pos;
        in_neg     = v.neg;
        in_red     = v.red;
    endtask

    task automatic drive_garbage();
        in_operand = 8'($urandom);
        in_not     = 8'($urandom);
        in_pos     = 8'($urandom);
        in_neg     = 8'($urandom);
        in_red     = 5'($urandom);
    endtask

    task automatic note_result(input logic [7:0] mask);
        if (mask != 8'h00) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_sat != 2'd3)     exp_sat = exp_sat + 2'd1;
        end
    endtask

    // One full transaction; offers garbage with in_valid=1 while busy to confirm it is ignored.
    task automatic run_txn(input vec_t v, input int hold);
        int   n;
        logic busy_ok;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
        drive_vec(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive_garbage();
        note_result(v.mask);
        n       = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 20) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; n++;
        end
        chk("latency_edges", n, 32'd8);
        chk("in_ready_low_scan", {31'd0, busy_ok}, 32'd1);
        chk("err_mask", {24'd0, out_err_mask}, {24'd0, v.mask});
        chk("pass", {31'd0, out_pass}, {31'd0, (v.mask == 8'h00)});
        chk("err_count", {16'd0, err_count}, {16'd0, exp_cnt});
        chk("sat_count", {30'd0, s_err_count}, {30'd0, exp_sat});
        chk("sat_mask", {24'd0, s_out_err_mask, s_out_valid}, {24'd0, v.mask, 1'b1});
        chk("in_ready_low_report", {31'd0, in_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_stable", {20'd0, out_valid, in_ready, out_pass, out_err_mask, 1'b0},
                {20'd0, 1'b1, 1'b0, (v.mask == 8'h00), v.mask, 1'b0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_handshake", {22'd0, out_valid, in_ready, out_err_mask}, {22'd0, 1'b0, 1'b1, v.mask});
    endtask

    initial begin
        int n;
        int acc_t[$];

        // a, ~a, +a, -a, {!a,~^a,^a,|a,&a}, expected mask
        vt[0] = '{8'h00, 8'hFF, 8'h00, 8'h00, 5'b11000, 8'h00};
        vt[1] = '{8'h80, 8'h7F, 8'h80, 8'h80, 5'b00110, 8'h00};
        vt[2] = '{8'h80, 8'h7F, 8'h80, 8'h00, 5'b00110, 8'h80};
        vt[3] = '{8'hFF, 8'h00, 8'hFF, 8'h01, 5'b01010, 8'h01};
        vt[4] = '{8'h01, 8'hFE, 8'h01, 8'hFF, 5'b00110, 8'h00};
        vt[5] = '{8'h03, 8'hFC, 8'h03, 8'hFD, 5'b01010, 8'h00};
        vt[6] = '{8'h03, 8'hFD, 8'h02, 8'hFD, 5'b10101, 8'h7F};
        vt[7] = '{8'h5A, 8'hA5, 8'h5A, 8'hA6, 5'b01000, 8'h02};
        vt[8] = '{8'h5A, 8'hA5, 8'h5A, 8'hA6, 5'b01110, 8'h04};
        vt[9] = '{8'h00, 8'hFF, 8'h00, 8'h00, 5'b01000, 8'h10};

        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 16'd0;
        exp_sat   = 2'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_garbage();

        #1;
        chk("reset_in_ready",  {30'd0, in_ready, s_in_ready}, 32'd3);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_pass",  {31'd0, out_pass}, 32'd0);
        chk("reset_err_mask",  {24'd0, out_err_mask}, 32'd0);
        chk("reset_err_count", {16'd0, err_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors; vt[3] also holds out_ready low for 5 cycles.
        for (int i = 0; i < 10; i++)
            run_txn(vt[i], (i == 3) ? 5 : 0);

        // Back-to-back: in_valid and out_ready both held high.
        drive_vec(vt[1]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) acc_t.push_back(c);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        out_ready = 1'b0;
        chk("b2b_accepts", acc_t.size(), 32'd4);
        for (int k = 1; k < acc_t.size(); k++)
            chk("b2b_spacing", acc_t[k] - acc_t[k-1], 32'd10);
        chk("b2b_count", {16'd0, err_count}, {16'd0, exp_cnt});

        // Reset during SCAN bit 3 aborts the transaction and clears the counter.
        chk("count_before_reset", {16'd0, err_count}, {16'd0, exp_cnt});
        drive_vec(vt[2]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midscan_rst", {29'd0, out_valid, in_ready, (err_count == 16'd0)}, 32'd3);
        exp_cnt = 16'd0;
        exp_sat = 2'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        run_txn(vt[0], 0);
        run_txn(vt[2], 0);

        // Saturation: narrow counter must stop at 3 while the wide one keeps counting.
        run_txn(vt[6], 0);
        run_txn(vt[7], 0);
        run_txn(vt[9], 0);
        chk("sat_final", {30'd0, s_err_count}, 32'd3);
        chk("wide_final", {16'd0, err_count}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
